// File: rtl/pixel_stream_rx_pkg.sv
// Shared types and raster defaults for the pixel stream receiver and the input handlers.
package pixel_stream_rx_pkg;

    localparam int unsigned DefaultCols = 16;
    localparam int unsigned DefaultRows = 16;

    typedef enum logic {StSync, StRun} state_e;

    typedef struct packed {
        logic [7:0] y;
        logic [7:0] x;
    } point_t;

endpackage

// File: rtl/pixel_stream_rx_point_fifo.sv
// Show-ahead point FIFO; a push while full is accepted only if a pop happens on the same edge.
module pixel_stream_rx_point_fifo #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 8
) (
    input  logic             Clk,
    input  logic             nReset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q;
    logic [PtrW-1:0]  rd_ptr_q;
    logic [CntW-1:0]  count_q;
    logic             pop_ok;
    logic             push_ok;

    assign full    = (count_q == CntW'(DEPTH));
    assign empty   = (count_q == '0);
    assign head    = mem_q[rd_ptr_q];
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= wr_ptr_q + PtrW'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            count_q <= count_q + CntW'(push_ok) - CntW'(pop_ok);
        end
    end

endmodule

// File: rtl/pixel_stream_rx.sv
// Rebuilds pixel coordinates from Frame/Line markers and queues edge-pixel points for voting.
module pixel_stream_rx
    import pixel_stream_rx_pkg::*;
#(
    parameter int unsigned COLS  = DefaultCols,
    parameter int unsigned ROWS  = DefaultRows,
    parameter int unsigned DEPTH = 8
) (
    input  logic       Clk,
    input  logic       nReset,
    input  logic [7:0] Pixel,
    input  logic       Frame,
    input  logic       Line,
    input  logic [7:0] Threshold,
    output logic       PointValid,
    input  logic       PointReady,
    output logic [7:0] PointX,
    output logic [7:0] PointY,
    output logic       FrameDone,
    output logic       FrameErr,
    output logic       Overflow
);

    localparam logic [7:0] ColLast = 8'(COLS - 1);
    localparam logic [7:0] RowLast = 8'(ROWS - 1);

    logic [7:0] pix_s1;
    logic [7:0] thr_s1;
    logic       frame_s1;
    logic       line_s1;

    state_e     state_q;
    state_e     state_d;
    logic [7:0] col_q;
    logic [7:0] col_d;
    logic [7:0] row_q;
    logic [7:0] row_d;
    logic       accept;
    logic       err;
    logic       push;
    logic       fifo_full;
    logic       fifo_empty;
    logic       frame_done_q;
    logic       frame_err_q;
    logic       overflow_q;
    point_t     push_pt;
    point_t     head_pt;

    // Decode the S1 markers against the coordinates of the previously accepted pixel.
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        accept  = 1'b0;
        err     = 1'b0;
        if (frame_s1 && !line_s1) begin
            err     = 1'b1;
            state_d = StSync;
        end else if (state_q == StSync) begin
            if (frame_s1) begin
                state_d = StRun;
                col_d   = '0;
                row_d   = '0;
                accept  = 1'b1;
            end
        end else if (frame_s1) begin
            col_d  = '0;
            row_d  = '0;
            accept = 1'b1;
            err    = !(col_q == ColLast && row_q == RowLast);
        end else if (line_s1) begin
            if (col_q == ColLast && row_q < RowLast) begin
                col_d  = '0;
                row_d  = row_q + 8'd1;
                accept = 1'b1;
            end else begin
                err     = 1'b1;
                state_d = StSync;
            end
        end else if (col_q < ColLast) begin
            col_d  = col_q + 8'd1;
            accept = 1'b1;
        end else begin
            err     = 1'b1;
            state_d = StSync;
        end
    end

    assign push      = accept && (pix_s1 >= thr_s1);
    assign push_pt.x = col_d;
    assign push_pt.y = row_d;

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            pix_s1       <= '0;
            thr_s1       <= '0;
            frame_s1     <= 1'b0;
            line_s1      <= 1'b0;
            state_q      <= StSync;
            col_q        <= '0;
            row_q        <= '0;
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            pix_s1       <= Pixel;
            thr_s1       <= Threshold;
            frame_s1     <= Frame;
            line_s1      <= Line;
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            frame_done_q <= accept && col_d == ColLast && row_d == RowLast;
            frame_err_q  <= err;
            // A full FIFO is never empty, so a ready consumer always frees a slot.
            overflow_q   <= push && fifo_full && !PointReady;
        end
    end

    pixel_stream_rx_point_fifo #(
        .WIDTH($bits(point_t)),
        .DEPTH(DEPTH)
    ) u_point_fifo (
        .Clk      (Clk),
        .nReset   (nReset),
        .push     (push),
        .push_data(push_pt),
        .pop      (PointReady),
        .head     (head_pt),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign PointValid = !fifo_empty;
    assign PointX     = head_pt.x;
    assign PointY     = head_pt.y;
    assign FrameDone  = frame_done_q;
    assign FrameErr   = frame_err_q;
    assign Overflow   = overflow_q;

endmodule

// File: tb/tb_pixel_stream_rx.sv
// Directed and randomized checks of pixel_stream_rx against a raster-index reference model.
module tb_pixel_stream_rx;

    localparam int COLS  = 4;
    localparam int ROWS  = 3;
    localparam int DEPTH = 8;
    localparam int N     = COLS * ROWS;

    logic       Clk = 1'b0;
    logic       nReset = 1'b0;
    logic [7:0] Pixel = '0;
    logic       Frame = 1'b0;
    logic       Line = 1'b0;
    logic [7:0] Threshold = '0;
    logic       PointReady = 1'b0;
    logic       PointValid;
    logic [7:0] PointX;
    logic [7:0] PointY;
    logic       FrameDone;
    logic       FrameErr;
    logic       Overflow;

    always #5 Clk = ~Clk;

    pixel_stream_rx #(
        .COLS (COLS),
        .ROWS (ROWS),
        .DEPTH(DEPTH)
    ) dut (
        .Clk       (Clk),
        .nReset    (nReset),
        .Pixel     (Pixel),
        .Frame     (Frame),
        .Line      (Line),
        .Threshold (Threshold),
        .PointValid(PointValid),
        .PointReady(PointReady),
        .PointX    (PointX),
        .PointY    (PointY),
        .FrameDone (FrameDone),
        .FrameErr  (FrameErr),
        .Overflow  (Overflow)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference model: tracks the linear raster index of the last accepted pixel.
    logic [15:0] mq[$];   // {y,x}
    logic [7:0]  s1_pix, s1_thr;
    logic        s1_f, s1_l;
    logic        e_done = 1'b0, e_err = 1'b0, e_ovf = 1'b0;
    bit          m_sync;
    int          m_last;

    initial begin
        bit m_pop, m_ok, m_push;
        int idx;
        forever begin
            @(posedge Clk or negedge nReset);
            if (!nReset) begin
                mq.delete();
                m_sync = 0; m_last = 0;
                s1_pix = '0; s1_thr = '0; s1_f = 1'b0; s1_l = 1'b0;
                e_done = 1'b0; e_err = 1'b0; e_ovf = 1'b0;
            end else begin
                m_pop = (mq.size() != 0) && PointReady;
                m_ok = 0; idx = 0;
                e_err = 1'b0; e_done = 1'b0; e_ovf = 1'b0;
                if (s1_f && !s1_l) begin
                    e_err = 1'b1; m_sync = 0;
                end else if (!m_sync) begin
                    if (s1_f) begin m_sync = 1; idx = 0; m_ok = 1; end
                end else if (s1_f) begin
                    idx = 0; m_ok = 1; e_err = (m_last != N - 1);
                end else if (s1_l) begin
                    if ((m_last + 1) % COLS == 0 && m_last + 1 < N) begin
                        idx = m_last + 1; m_ok = 1;
                    end else begin
                        e_err = 1'b1; m_sync = 0;
                    end
                end else if ((m_last + 1) % COLS != 0) begin
                    idx = m_last + 1; m_ok = 1;
                end else begin
                    e_err = 1'b1; m_sync = 0;
                end
                m_push = m_ok && (s1_pix >= s1_thr);
                if (m_ok) begin
                    m_last = idx;
                    e_done = (idx == N - 1);
                end
                if (m_pop) void'(mq.pop_front());
                if (m_push) begin
                    if (mq.size() < DEPTH) mq.push_back({8'(idx / COLS), 8'(idx % COLS)});
                    else e_ovf = 1'b1;
                end
                s1_pix = Pixel; s1_thr = Threshold; s1_f = Frame; s1_l = Line;
            end
        end
    end

    int          cyc = 0;
    logic [15:0] popped[$];   // {x,y}
    int          done_cnt = 0, err_cnt = 0, ovf_cnt = 0, done_cyc = 0, drive_cyc = 0;

    always_ff @(posedge Clk) cyc <= cyc + 1;

    // Compare and monitor, away from the active edge.
    initial begin
        forever begin
            @(negedge Clk);
            check("point_valid", 32'(PointValid), 32'(mq.size() != 0));
            if (mq.size() != 0) check("point_yx", {16'h0, PointY, PointX}, {16'h0, mq[0]});
            check("frame_done", 32'(FrameDone), 32'(e_done));
            check("frame_err", 32'(FrameErr), 32'(e_err));
            check("overflow", 32'(Overflow), 32'(e_ovf));
            if (PointValid && PointReady) popped.push_back({PointX, PointY});
            if (FrameDone) begin done_cnt++; done_cyc = cyc; end
            if (FrameErr) err_cnt++;
            if (Overflow) ovf_cnt++;
        end
    end

    logic [7:0] fpx [N];

    task automatic drive(input logic [7:0] p, input logic f, input logic l);
        @(posedge Clk);
        #1;
        Pixel = p; Frame = f; Line = l;
        drive_cyc = cyc;
    endtask

    task automatic send_frame();
        for (int i = 0; i < N; i++) drive(fpx[i], i == 0, i % COLS == 0);
    endtask

    // One non-marker pixel, then wait until the last frame pixel's pulses are counted.
    task automatic finish_frame();
        drive(8'd0, 1'b0, 1'b0);
        repeat (2) @(posedge Clk);
    endtask

    task automatic do_reset();
        @(posedge Clk);
        #1;
        nReset = 1'b0; Pixel = '0; Frame = 1'b0; Line = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        nReset = 1'b1;
    endtask

    function automatic logic [15:0] pop_at(input int i);
        return (i < popped.size()) ? popped[i] : 16'hffff;
    endfunction

    initial begin
        int d0, e0, o0, lastc, pr;
        logic f, l;
        Threshold = 8'd128;

        // Clean frame with edges at (2,1) and (3,2).
        do_reset();
        PointReady = 1'b1;
        foreach (fpx[i]) fpx[i] = 8'd10;
        fpx[1 * COLS + 2] = 8'd200;
        fpx[2 * COLS + 3] = 8'd200;
        popped.delete(); d0 = done_cnt; e0 = err_cnt;
        send_frame();
        lastc = drive_cyc;
        finish_frame();
        check("t1_points", popped.size(), 2);
        check("t1_first", pop_at(0), {8'd2, 8'd1});
        check("t1_second", pop_at(1), {8'd3, 8'd2});
        check("t1_done_count", done_cnt - d0, 1);
        check("t1_done_latency", done_cyc - lastc, 2);
        check("t1_no_err", err_cnt - e0, 0);

        // Threshold comparison is inclusive.
        do_reset();
        foreach (fpx[i]) fpx[i] = 8'd0;
        fpx[0] = 8'd128;
        fpx[1] = 8'd127;
        popped.delete();
        send_frame();
        finish_frame();
        check("t2_points", popped.size(), 1);
        check("t2_point", pop_at(0), 16'h0000);

        // Premature Line, ignored pixels, then a clean resync.
        do_reset();
        popped.delete(); e0 = err_cnt;
        drive(8'd0, 1'b1, 1'b1);
        drive(8'd0, 1'b0, 1'b0);
        drive(8'd255, 1'b0, 1'b1);
        repeat (3) drive(8'd255, 1'b0, 1'b0);
        drive(8'd255, 1'b0, 1'b1);
        foreach (fpx[i]) fpx[i] = 8'd0;
        fpx[0] = 8'd255;
        send_frame();
        finish_frame();
        check("t3_err_count", err_cnt - e0, 1);
        check("t3_points", popped.size(), 1);
        check("t3_restart", pop_at(0), 16'h0000);

        // All-edge frame into a stalled consumer.
        do_reset();
        PointReady = 1'b0;
        popped.delete(); o0 = ovf_cnt;
        foreach (fpx[i]) fpx[i] = 8'd255;
        send_frame();
        finish_frame();
        check("t4_overflows", ovf_cnt - o0, 4);
        check("t4_held", popped.size(), 0);
        #1 PointReady = 1'b1;
        repeat (12) @(posedge Clk);
        check("t4_drained", popped.size(), 8);
        for (int i = 0; i < 8; i++) check("t4_order", pop_at(i), {8'(i % COLS), 8'(i / COLS)});

        // Push into a full FIFO on the same edge as a pop.
        do_reset();
        PointReady = 1'b0;
        popped.delete(); o0 = ovf_cnt;
        foreach (fpx[i]) fpx[i] = (i < 8 || i == 10) ? 8'd255 : 8'd0;
        for (int i = 0; i < N; i++) begin
            drive(fpx[i], i == 0, i % COLS == 0);
            if (i == N - 1) PointReady = 1'b1;
        end
        finish_frame();
        repeat (12) @(posedge Clk);
        check("t5_no_overflow", ovf_cnt - o0, 0);
        check("t5_points", popped.size(), 9);
        check("t5_first", pop_at(0), 16'h0000);
        check("t5_last", pop_at(8), {8'd2, 8'd2});

        // Reset mid-frame with three points queued.
        do_reset();
        PointReady = 1'b0;
        for (int i = 0; i < 6; i++) drive((i < 3) ? 8'd255 : 8'd0, i == 0, i % COLS == 0);
        @(posedge Clk);
        #1;
        check("t6_model_queued", mq.size(), 3);
        check("t6_valid_before", 32'(PointValid), 1);
        nReset = 1'b0;
        #1;
        check("t6_valid_in_reset", 32'(PointValid), 0);
        repeat (2) @(posedge Clk);
        #1;
        nReset = 1'b1;
        PointReady = 1'b1;
        popped.delete();
        for (int i = 0; i < 6; i++) drive(8'd255, 1'b0, 1'(i % 2));
        repeat (3) @(posedge Clk);
        #1;
        check("t6_ignored", popped.size(), 0);
        check("t6_valid_after", 32'(PointValid), 0);

        // Randomized frames, thresholds, backpressure, marker faults and resets.
        do_reset();
        for (int fr = 0; fr < 150; fr++) begin
            Threshold = 8'($urandom);
            pr = $urandom_range(1, 9);
            if ($urandom_range(0, 29) == 0) do_reset();
            for (int i = 0; i < N; i++) begin
                int r;
                f = (i == 0);
                l = (i % COLS == 0);
                r = $urandom_range(0, 49);
                if (r == 0) f = ~f;
                else if (r == 1) l = ~l;
                else if (r == 2) break;
                drive(8'($urandom), f, l);
                PointReady = ($urandom_range(0, 9) < pr);
            end
        end
        repeat (4) @(posedge Clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pixel_stream_rx.md
Name: pixel_stream_rx

Overview:
- Receiving end of the Pixel/Frame/Line raster stream that the input-handler blocks drive.
- Rebuilds the column and row of every pixel from the Frame/Line markers.
- Thresholds each pixel and queues the (col,row) of every edge pixel in a small FIFO.
- The FIFO feeds the Hough voting stage over a valid/ready handshake. The block also flags framing errors and signals end of frame.

Parameters:
- COLS, 16, pixels per line (2..256)
- ROWS, 16, lines per frame (2..256)
- DEPTH, 8, point FIFO depth (power of 2, >=2)

Ports:
- Clk  input  1  clock
- nReset  input  1  asynchronous active-low reset
- Pixel  input  8  pixel value, one valid pixel every cycle
- Frame  input  1  high with pixel (0,0) of a frame
- Line  input  1  high with the col-0 pixel of every line (also high with Frame)
- Threshold  input  8  edge threshold, quasi-static
- PointValid  output  1  FIFO non-empty
- PointReady  input  1  consumer accepts head point
- PointX  output  8  column of head point
- PointY  output  8  row of head point
- FrameDone  output  1  one-cycle pulse, last pixel of frame processed
- FrameErr  output  1  one-cycle pulse, framing violation detected
- Overflow  output  1  one-cycle pulse, edge point dropped on full FIFO

Behaviour:
- Interface: reset nReset, asynchronous, active-low; clock Clk. All state on posedge Clk.
- Reset values: all outputs 0, FIFO empty, state SYNC, col/row counters 0, input stage registers 0.
- Input stage: Pixel, Frame, Line and Threshold are registered every cycle (stage S1). All decisions act on the S1 copy.
- State machine:
  - SYNC: ignore data until S1 Frame=1. That pixel is (0,0) and the state moves to RUN.
  - RUN, S1 Frame=1: col=0, row=0. If the previous pixel was not (COLS-1,ROWS-1), pulse FrameErr. Stay in RUN, because Frame always resyncs.
  - RUN, S1 Line=1 with Frame=0: valid only if the previous col==COLS-1 and row<ROWS-1. Then col=0, row+1. Otherwise pulse FrameErr, go to SYNC, and do not process that pixel.
  - RUN, Line=0: valid only if the previous col<COLS-1. Then col+1. Otherwise pulse FrameErr, go to SYNC, and do not process that pixel.
  - Frame=1 with Line=0 is a violation: pulse FrameErr, go to SYNC.
- Processing a pixel (RUN, valid):
  - If Pixel>=Threshold (unsigned), write {row,col} to the FIFO on the next edge.
  - If that pixel is (COLS-1,ROWS-1), pulse FrameDone on the same edge as the write.
- Latency: a pixel presented in cycle t is in S1 after edge t. Its FIFO write happens at edge t+1. PointValid rises after edge t+1 if the FIFO was empty. Total: 2 edges.
- FIFO and handshake:
  - Show-ahead: PointX/PointY are valid whenever PointValid=1.
  - Pop on PointValid&&PointReady.
  - Simultaneous push and pop is legal at any occupancy, including full: the occupancy count is unchanged and the point is accepted.
  - Push while full without a pop: drop the point, pulse Overflow, leave the FIFO unchanged.
  - Pointers wrap modulo DEPTH. Occupancy counter width is clog2(DEPTH)+1.
- Counters are 8 bits and never exceed COLS-1/ROWS-1 in RUN.
- Reset mid-operation: everything returns to reset values and queued points are discarded. The next frame needs a Frame marker.
- FrameErr, FrameDone and Overflow are single-cycle pulses, not sticky. FrameErr and Overflow may pulse in the same cycle.

Decomposition:
- Shared package: the state enum (SYNC, RUN), a point struct {y[7:0], x[7:0]}, and the default COLS/ROWS constants shared with the input handlers.
- One sub-module: point_fifo. Parameterised width 16 and DEPTH, with synchronous push/pop, full/empty flags, async active-low reset, and defined push-pop-when-full behaviour.

Test Plan:
- COLS=4, ROWS=3, Threshold=128, PointReady=1. Clean frame with Pixel=200 only at (2,1) and (3,2).
  - Exactly two points come out: (2,1), then (3,2).
  - FrameDone pulses once, 2 edges after pixel (3,2) is driven.
  - FrameErr stays 0.
- Same frame with Pixel=128 at (0,0) and 127 at (1,0): one point (0,0) comes out, confirming the >= comparison.
- Line asserted after only 2 pixels of row 0:
  - FrameErr pulses once and no points are emitted until the next Frame.
  - After a clean Frame, the point coordinates restart at (0,0).
- All 12 pixels = 255, DEPTH=8, PointReady=0:
  - 8 points are queued (0,0) through (3,1); Overflow pulses 4 times.
  - Raising PointReady drains exactly those 8 in order.
- FIFO full with PointReady=1 and a new edge pixel arriving: the count stays 8, no Overflow, and the new point ends up last in order.
- nReset asserted mid-frame with 3 points queued:
  - PointValid drops to 0 immediately and the FIFO is empty.
  - Pixels before the next Frame are ignored.
